// File: rtl/shift_sequencer.sv
// Multi-cycle controller for a 32-bit barrel shifter. It executes an
// ARM register-specified shift (amount 0..255) as a series of steps of at
// most MAX_STEP and produces the ARM shifter carry-out.
//
// Ports:
//   clk, reset                      clock; synchronous active-high reset
//   start_valid/start_ready         request handshake (op, amount, operand, carry_in)
//   result_valid/result_ready       result handshake (result, carry_out)
//   busy                            high while an operation is in flight (RUN or DONE)
//   sh_shamt5, sh_sel, sh_operand   drive the external shifter
//   sh_result                       combinational result from the external shifter
module shift_sequencer #(
    parameter int unsigned MAX_STEP = 31,
    parameter int unsigned N        = 32
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         start_valid,
    output logic         start_ready,
    input  logic [1:0]   op,
    input  logic [7:0]   amount,
    input  logic [N-1:0] operand,
    input  logic         carry_in,
    output logic         result_valid,
    input  logic         result_ready,
    output logic [N-1:0] result,
    output logic         carry_out,
    output logic         busy,
    output logic [4:0]   sh_shamt5,
    output logic [1:0]   sh_sel,
    output logic [N-1:0] sh_operand,
    input  logic [N-1:0] sh_result
);

    localparam logic [1:0] OP_LSL   = 2'b00;
    localparam logic [7:0] STEP_MAX = 8'(MAX_STEP);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t         state, state_nxt;
    logic [N-1:0]   acc, acc_nxt;
    logic [7:0]     remaining, remaining_nxt;
    logic [1:0]     op_r, op_r_nxt;
    logic           carry_r, carry_r_nxt;

    logic [4:0]     step_c;
    logic [4:0]     carry_idx_c;

    // Step size for this cycle: the whole remainder, capped at MAX_STEP.
    assign step_c = (remaining > STEP_MAX) ? 5'(MAX_STEP) : remaining[4:0];

    // Bit that falls off the end during a shift by step_c: the top side for
    // LSL, the bottom side for LSR/ASR/ROR (for ROR it becomes the new MSB).
    assign carry_idx_c = (op_r == OP_LSL) ? 5'(6'd32 - 6'(step_c))
                                          : 5'(step_c - 5'd1);

    // State and datapath registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            acc       <= '0;
            remaining <= '0;
            op_r      <= '0;
            carry_r   <= 1'b0;
        end else begin
            state     <= state_nxt;
            acc       <= acc_nxt;
            remaining <= remaining_nxt;
            op_r      <= op_r_nxt;
            carry_r   <= carry_r_nxt;
        end
    end

    // Next-state, datapath update and shifter drive.
    always_comb begin
        state_nxt     = state;
        acc_nxt       = acc;
        remaining_nxt = remaining;
        op_r_nxt      = op_r;
        carry_r_nxt   = carry_r;
        sh_shamt5     = 5'd0;
        sh_sel        = 2'b00;

        case (state)
            IDLE: begin
                if (start_valid) begin
                    op_r_nxt      = op;
                    acc_nxt       = operand;
                    carry_r_nxt   = carry_in;
                    remaining_nxt = amount;
                    state_nxt     = (amount != 8'd0) ? RUN : DONE;
                end
            end
            RUN: begin
                sh_shamt5     = step_c;
                sh_sel        = op_r;
                acc_nxt       = sh_result;
                remaining_nxt = remaining - 8'(step_c);
                carry_r_nxt   = acc[carry_idx_c];
                if (remaining == 8'(step_c)) begin
                    state_nxt = DONE;
                end
            end
            DONE: begin
                if (result_ready) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Outputs decode directly from registers; result/carry hold in IDLE.
    assign start_ready  = (state == IDLE);
    assign result_valid = (state == DONE);
    assign busy         = (state != IDLE);
    assign result       = acc;
    assign carry_out    = carry_r;
    assign sh_operand   = acc;

endmodule

// File: tb/tb_shift_sequencer.sv
// Self-checking bench for shift_sequencer: a behavioural barrel shifter is
// attached to the sh_* port, expected ARM shift results are queued at
// request acceptance and compared when the result handshake completes.
module tb_shift_sequencer;

    logic        clk = 1'b0;
    logic        reset;
    logic        start_valid;
    logic        start_ready;
    logic [1:0]  op;
    logic [7:0]  amount;
    logic [31:0] operand;
    logic        carry_in;
    logic        result_valid;
    logic        result_ready;
    logic [31:0] result;
    logic        carry_out;
    logic        busy;
    logic [4:0]  sh_shamt5;
    logic [1:0]  sh_sel;
    logic [31:0] sh_operand;
    logic [31:0] sh_result;

    typedef struct packed {
        logic [31:0] res;
        logic        c;
    } exp_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    always #5 clk = ~clk;

    shift_sequencer dut (
        .clk          (clk),
        .reset        (reset),
        .start_valid  (start_valid),
        .start_ready  (start_ready),
        .op           (op),
        .amount       (amount),
        .operand      (operand),
        .carry_in     (carry_in),
        .result_valid (result_valid),
        .result_ready (result_ready),
        .result       (result),
        .carry_out    (carry_out),
        .busy         (busy),
        .sh_shamt5    (sh_shamt5),
        .sh_sel       (sh_sel),
        .sh_operand   (sh_operand),
        .sh_result    (sh_result)
    );

    // Behavioural 32-bit barrel shifter with a 5-bit amount.
    always_comb begin
        logic [63:0] dbl;
        dbl = {sh_operand, sh_operand} >> sh_shamt5;
        case (sh_sel)
            2'b00:   sh_result = sh_operand << sh_shamt5;
            2'b01:   sh_result = sh_operand >> sh_shamt5;
            2'b10:   sh_result = 32'($signed(sh_operand) >>> sh_shamt5);
            default: sh_result = dbl[31:0];
        endcase
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Reference ARM register-specified shift, written directly from the
    // architectural definition rather than by chunking.
    function automatic exp_t arm_shift(input logic [1:0] o, input logic [7:0] amt,
                                       input logic [31:0] x, input logic cin);
        exp_t e;
        int   a;
        int   r;
        a = int'(amt);
        e.res = x;
        e.c   = cin;
        if (a != 0) begin
            case (o)
                2'b00: begin
                    if (a < 32)       begin e.res = x << a; e.c = x[5'(32 - a)]; end
                    else if (a == 32) begin e.res = '0;     e.c = x[0];          end
                    else              begin e.res = '0;     e.c = 1'b0;          end
                end
                2'b01: begin
                    if (a < 32)       begin e.res = x >> a; e.c = x[5'(a - 1)];  end
                    else if (a == 32) begin e.res = '0;     e.c = x[31];         end
                    else              begin e.res = '0;     e.c = 1'b0;          end
                end
                2'b10: begin
                    if (a < 32) begin
                        e.res = 32'($signed(x) >>> a);
                        e.c   = x[5'(a - 1)];
                    end else begin
                        e.res = {32{x[31]}};
                        e.c   = x[31];
                    end
                end
                default: begin
                    r = a % 32;
                    if (r == 0) begin
                        e.res = x;
                        e.c   = x[31];
                    end else begin
                        e.res = (x >> r) | (x << (32 - r));
                        e.c   = e.res[31];
                    end
                end
            endcase
        end
        return e;
    endfunction

    // Scoreboard: compare every completed result handshake.
    always @(negedge clk) begin
        exp_t e;
        if (!reset && result_valid && result_ready) begin
            check("sb_has_entry", 64'(sb.size() != 0), 64'd1);
            if (sb.size() != 0) begin
                e = sb.pop_front();
                check("result", 64'(result), 64'(e.res));
                check("carry_out", 64'(carry_out), 64'(e.c));
            end
        end
    end

    // One complete transaction; entered and left at posedge+1.
    task automatic run_req(input logic [1:0] o, input logic [7:0] amt,
                           input logic [31:0] x, input logic cin, input int hold);
        logic [31:0] held_r;
        logic        held_c;
        int          cyc;
        bit          got;
        check("start_ready_idle", 64'(start_ready), 64'd1);
        start_valid = 1'b1;
        op          = o;
        amount      = amt;
        operand     = x;
        carry_in    = cin;
        @(posedge clk);
        sb.push_back(arm_shift(o, amt, x, cin));
        #1;
        start_valid = 1'b0;
        op          = 2'($urandom);
        amount      = 8'($urandom);
        operand     = $urandom;
        carry_in    = 1'($urandom);
        cyc = 0;
        got = 1'b0;
        for (int i = 1; i <= 20 && !got; i++) begin
            @(negedge clk);
            cyc = i;
            if (i == 1 && amt != 8'd0) begin
                check("first_step", 64'(sh_shamt5), (amt > 8'd31) ? 64'd31 : 64'(amt));
                check("busy_run", 64'(busy), 64'd1);
            end
            if (result_valid) got = 1'b1;
        end
        check("latency", 64'(cyc), 64'((int'(amt) + 30) / 31 + 1));
        held_r = result;
        held_c = carry_out;
        for (int h = 0; h < hold; h++) begin
            @(posedge clk);
            #1;
            start_valid = 1'b1;
            @(negedge clk);
            check("hold_valid", 64'(result_valid), 64'd1);
            check("hold_result", 64'(result), 64'(held_r));
            check("hold_carry", 64'(carry_out), 64'(held_c));
            check("hold_start_ready", 64'(start_ready), 64'd0);
        end
        @(posedge clk);
        #1;
        start_valid  = 1'b0;
        result_ready = 1'b1;
        @(posedge clk);
        #1;
        result_ready = 1'b0;
        @(negedge clk);
        check("valid_drop", 64'(result_valid), 64'd0);
        check("ready_after", 64'(start_ready), 64'd1);
        check("busy_after", 64'(busy), 64'd0);
        @(posedge clk);
        #1;
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_start_ready"}, 64'(start_ready), 64'd1);
        check({tag, "_valid"}, 64'(result_valid), 64'd0);
        check({tag, "_result"}, 64'(result), 64'd0);
        check({tag, "_carry"}, 64'(carry_out), 64'd0);
        check({tag, "_busy"}, 64'(busy), 64'd0);
        check({tag, "_shamt"}, 64'(sh_shamt5), 64'd0);
        check({tag, "_sel"}, 64'(sh_sel), 64'd0);
        check({tag, "_shop"}, 64'(sh_operand), 64'd0);
    endtask

    initial begin
        logic [7:0] bnd [8];
        bnd = '{8'd1, 8'd31, 8'd32, 8'd33, 8'd62, 8'd63, 8'd64, 8'd255};
        reset        = 1'b1;
        start_valid  = 1'b0;
        op           = 2'b00;
        amount       = 8'd0;
        operand      = 32'd0;
        carry_in     = 1'b0;
        result_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_reset_outputs("rst");
        reset = 1'b0;
        @(posedge clk);
        #1;

        run_req(2'b00, 8'd4,   32'h0000_00F1, 1'b0, 0);
        run_req(2'b00, 8'd32,  32'h8000_0001, 1'b0, 0);
        run_req(2'b10, 8'd200, 32'h8000_0000, 1'b0, 1);
        run_req(2'b11, 8'd40,  32'h0000_00FF, 1'b0, 0);
        run_req(2'b01, 8'd0,   32'h1234_5678, 1'b1, 3);

        // Abort an LSR by 255 during its fourth RUN cycle.
        start_valid = 1'b1;
        op          = 2'b01;
        amount      = 8'd255;
        operand     = 32'hFFFF_FFFF;
        carry_in    = 1'b1;
        @(posedge clk);
        #1;
        start_valid = 1'b0;
        repeat (3) begin
            @(posedge clk);
            #1;
        end
        check("abort_in_run", 64'(busy), 64'd1);
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        check_reset_outputs("abort");
        run_req(2'b01, 8'd5, 32'hF000_00F0, 1'b0, 0);

        foreach (bnd[i]) begin
            for (int o = 0; o < 4; o++) begin
                run_req(2'(o), bnd[i], $urandom, 1'($urandom), 0);
            end
        end
        for (int k = 0; k < 24; k++) begin
            run_req(2'($urandom), 8'($urandom), $urandom, 1'($urandom), int'($urandom_range(0, 2)));
        end

        repeat (2) @(posedge clk);
        check("sb_drained", 64'(sb.size()), 64'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

endmodule
